bram_uart_mover: RTL

Parametrised command-driven data mover between the tester's block RAM and the UART byte streams. It is the successor to the single-byte processor FSM. It accepts a command with operation and address range from the verification controller, then does one of three things: streams BRAM words out to the transmitter, assembles received UART bytes into BRAM words, or fills a range with a constant. Word width, address width and BRAM read latency are configurable. Completion, range errors and abort are reported explicitly.

---
 rtl/bram_uart_mover_if.sv | 41 ++++
 rtl/bram_uart_mover.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bram_uart_mover_if.sv
// rtl/bram_uart_mover_if.sv - command, BRAM, UART byte and status signals of bram_uart_mover
// master is the controller/BRAM/UART side, slave is the mover itself.
interface bram_uart_mover_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_start_addr;
  logic [ADDR_W-1:0] cmd_end_addr;
  logic [DATA_W-1:0] cmd_fill;
  logic              abort;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_start_addr, cmd_end_addr, cmd_fill, abort,
    output bram_rdata, tx_ready, rx_byte, rx_valid,
    input  cmd_ready, bram_en, bram_we, bram_addr, bram_wdata, tx_byte, tx_valid,
    input  busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_start_addr, cmd_end_addr, cmd_fill, abort,
    input  bram_rdata, tx_ready, rx_byte, rx_valid,
    output cmd_ready, bram_en, bram_we, bram_addr, bram_wdata, tx_byte, tx_valid,
    output busy, done, err
  );
endinterface

// File: rtl/bram_uart_mover.sv
// rtl/bram_uart_mover.sv - command-driven mover between block RAM and UART byte streams
// READ streams words to tx LSB first, WRITE packs rx bytes into words, FILL writes a constant.
module bram_uart_mover #(
  parameter int  ADDR_W         = 16,
  parameter int  BYTES_PER_WORD = 1,
  parameter int  RD_LATENCY     = 1,
  localparam int DATA_W         = 8 * BYTES_PER_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  bram_uart_mover_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_TX_SEND, S_WR_COLLECT, S_FILL, S_FINISH
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_end;
  logic [DATA_W-1:0] r_fill, r_rdata, r_asm, r_wword, w_asm_word;
  logic [1:0]        r_bidx, r_cnt;
  logic              r_lat, r_fail, r_commit, r_abort_err;
  logic              w_accept, w_bad, w_abort, w_at_end, w_tx_hs, w_last_byte;
  logic              w_lat_done, w_commit, w_last_commit, w_rx_take, w_word_full;

  assign w_accept      = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_bad         = (bus.cmd_start_addr > bus.cmd_end_addr) || (bus.cmd_op == 2'b11);
  assign w_abort       = bus.abort && (r_state != S_IDLE);
  assign w_at_end      = (r_addr == r_end);
  assign w_tx_hs       = (r_state == S_TX_SEND) && bus.tx_ready;
  assign w_last_byte   = (r_bidx == 2'(BYTES_PER_WORD - 1));
  assign w_lat_done    = (r_lat == 1'(RD_LATENCY - 1));
  assign w_commit      = (r_state == S_WR_COLLECT) && r_commit;
  assign w_last_commit = w_commit && w_at_end;
  // Bytes arriving while the final word is being committed belong to no word.
  assign w_rx_take     = (r_state == S_WR_COLLECT) && bus.rx_valid && !w_last_commit;
  assign w_word_full   = w_rx_take && (r_cnt == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    w_asm_word = r_asm;
    w_asm_word[DATA_W-8 +: 8] = bus.rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_bad) begin
              w_next = S_FINISH;
            end else begin
              case (bus.cmd_op)
                2'b00:   w_next = S_RD_REQ;
                2'b01:   w_next = S_WR_COLLECT;
                default: w_next = S_FILL;
              endcase
            end
          end
        end
        S_RD_REQ:     w_next = S_RD_WAIT;
        S_RD_WAIT:    if (w_lat_done) w_next = S_TX_SEND;
        S_TX_SEND:    if (w_tx_hs && w_last_byte) w_next = w_at_end ? S_FINISH : S_RD_REQ;
        S_WR_COLLECT: if (w_last_commit) w_next = S_FINISH;
        S_FILL:       if (w_at_end) w_next = S_FINISH;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cmd_ready  = (r_state == S_IDLE);
    bus.busy       = (r_state != S_IDLE);
    bus.done       = (r_state == S_FINISH) && !r_fail;
    bus.err        = ((r_state == S_FINISH) && r_fail) || r_abort_err;
    bus.bram_en    = 1'b0;
    bus.bram_we    = 1'b0;
    bus.bram_addr  = '0;
    bus.bram_wdata = '0;
    bus.tx_valid   = 1'b0;
    bus.tx_byte    = 8'h00;
    case (r_state)
      S_RD_REQ: begin
        bus.bram_en   = 1'b1;
        bus.bram_addr = r_addr;
      end
      S_TX_SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_byte  = r_rdata[{r_bidx, 3'b000} +: 8];
      end
      S_WR_COLLECT: begin
        if (r_commit) begin
          bus.bram_en    = 1'b1;
          bus.bram_we    = 1'b1;
          bus.bram_addr  = r_addr;
          bus.bram_wdata = r_wword;
        end
      end
      S_FILL: begin
        bus.bram_en    = 1'b1;
        bus.bram_we    = 1'b1;
        bus.bram_addr  = r_addr;
        bus.bram_wdata = r_fill;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_end       <= '0;
      r_fill      <= '0;
      r_rdata     <= '0;
      r_asm       <= '0;
      r_wword     <= '0;
      r_bidx      <= '0;
      r_cnt       <= '0;
      r_lat       <= 1'b0;
      r_fail      <= 1'b0;
      r_commit    <= 1'b0;
      r_abort_err <= 1'b0;
    end else begin
      r_abort_err <= w_abort;
      if (w_accept) begin
        r_addr   <= bus.cmd_start_addr;
        r_end    <= bus.cmd_end_addr;
        r_fill   <= bus.cmd_fill;
        r_fail   <= w_bad;
        r_bidx   <= '0;
        r_cnt    <= '0;
        r_lat    <= 1'b0;
        r_commit <= 1'b0;
        r_asm    <= '0;
      end
      if (w_abort) begin
        r_commit <= 1'b0;
        r_cnt    <= '0;
        r_asm    <= '0;
      end else begin
        case (r_state)
          S_RD_WAIT: begin
            if (w_lat_done) begin
              r_rdata <= bus.bram_rdata;
              r_lat   <= 1'b0;
            end else begin
              r_lat <= r_lat + 1'b1;
            end
          end
          S_TX_SEND: begin
            if (w_tx_hs) begin
              if (w_last_byte) begin
                r_bidx <= '0;
                if (!w_at_end) r_addr <= r_addr + 1'b1;
              end else begin
                r_bidx <= r_bidx + 2'd1;
              end
            end
          end
          S_WR_COLLECT: begin
            if (w_commit && !w_at_end) r_addr <= r_addr + 1'b1;
            r_commit <= w_word_full;
            if (w_rx_take) begin
              if (w_word_full) begin
                r_wword <= w_asm_word;
                r_cnt   <= '0;
              end else begin
                r_asm[{r_cnt, 3'b000} +: 8] <= bus.rx_byte;
                r_cnt <= r_cnt + 2'd1;
              end
            end
          end
          S_FILL: if (!w_at_end) r_addr <= r_addr + 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule
